// File: rtl/pinacolada_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pinacolada_uart_pkg
// Purpose  : Shared state encoding, error codes and helpers for the UART
//            frame loader.
// Revision : 1.0 - initial release
// ============================================================================
package pinacolada_uart_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_LEN  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Insert a byte into lane idx of a little-endian word.
    function automatic logic [31:0] put_byte(
        input logic [31:0] word,
        input logic [1:0]  idx,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_idle_timer
// Purpose  : Clear/enable idle counter; expired marks the TIMEOUT_CYCLES-th
//            consecutive enabled cycle without a clear.
// Revision : 1.0 - initial release
// ============================================================================
module uart_idle_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || !i_en) begin
            cnt_d = '0;
        end else if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = i_en && !i_clr && (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/uart_rx_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_loader
// Purpose  : Decodes SYNC/ADDR/LEN/payload load frames from the UART byte
//            stream and issues 32-bit little-endian memory writes.
//            Optional trailing checksum byte: UART_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_loader
    import pinacolada_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  rx_byte,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    logic [2:0]  state_q,     state_d;
    logic [1:0]  idx_q,       idx_d;
    logic [15:0] len_q,       len_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] word_q,      word_d;
    logic        wr_valid_q,  wr_valid_d;
    logic [31:0] wr_addr_q,   wr_addr_d;
    logic [31:0] wr_data_q,   wr_data_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q,  err_code_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q,       sum_d;
`endif

    logic        w_timer_en;
    logic        w_expired;
    logic [31:0] w_word;

    assign w_word = put_byte(word_q, idx_q, rx_byte);

    // Inter-byte timer runs only while a frame byte is actually awaited.
    always_comb begin
        w_timer_en = 1'b0;
        case (state_q)
            ST_ADDR, ST_LEN: w_timer_en = 1'b1;
            ST_DATA:         w_timer_en = (len_q != 16'd0);
            ST_CSUM:         w_timer_en = !idx_q[0];
            default:         w_timer_en = 1'b0;
        endcase
    end

    uart_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_idle_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (rx_done),
        .i_en      (w_timer_en),
        .o_expired (w_expired)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        addr_d      = addr_q;
        word_d      = word_q;
        wr_valid_d  = wr_valid_q && !wr_ready;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A SYNC byte arriving while the abort pulse is high is ignored.
                if (rx_done && (rx_byte == SYNC_BYTE) && !frame_err_q) begin
                    state_d = ST_ADDR;
                    idx_d   = 2'd0;
                    len_d   = 16'd0;
                    addr_d  = 32'd0;
                    word_d  = 32'd0;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end

            ST_ADDR: begin
                if (rx_done) begin
                    addr_d = put_byte(addr_q, idx_q, rx_byte);
                    idx_d  = idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_byte;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = ST_LEN;
                    end
                end
            end

            ST_LEN: begin
                if (rx_done) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_byte;
`endif
                    if (idx_q[0]) begin
                        len_d = {rx_byte, len_q[7:0]};
                        idx_d = 2'd0;
                        if ({rx_byte, len_q[7:0]} == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        len_d = {8'h00, rx_byte};
                        idx_d = 2'd1;
                    end
                end
            end

            ST_DATA: begin
                if (len_q == 16'd0) begin
                    // Payload complete; hold until the final write is taken.
                    if (!wr_valid_d) begin
                        state_d = ST_DONE;
                    end
                end else if (rx_done) begin
                    word_d = w_word;
                    idx_d  = idx_q + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_byte;
`endif
                    if (idx_q == 2'd3) begin
                        if (wr_valid_q && !wr_ready) begin
                            state_d     = ST_IDLE;
                            wr_valid_d  = 1'b0;
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_OVERRUN;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = w_word;
                            addr_d     = addr_q + 32'd4;
                            len_d      = len_q - 16'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                            if (len_q == 16'd1) begin
                                state_d = ST_CSUM;
                                idx_d   = 2'd0;
                            end
`endif
                        end
                    end
                end
            end

            ST_CSUM: begin
`ifdef UART_LOADER_CHECKSUM_EN
                // idx_q[0] marks a matching CSUM already received.
                if (idx_q[0]) begin
                    if (!wr_valid_d) begin
                        state_d = ST_DONE;
                    end
                end else if (rx_done) begin
                    if (rx_byte != sum_q) begin
                        state_d     = ST_IDLE;
                        wr_valid_d  = 1'b0;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end else if (!wr_valid_d) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = 2'd1;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_expired) begin
            state_d     = ST_IDLE;
            wr_valid_d  = 1'b0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            len_q       <= 16'd0;
            addr_q      <= 32'd0;
            word_q      <= 32'd0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 32'd0;
            wr_data_q   <= 32'd0;
            frame_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_loader
// Purpose  : Self-checking bench for uart_rx_loader (directed + random frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_loader;

    localparam int TO = 50;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done;
    logic [7:0]  rx_byte;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  err_code;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          ready_mode = 0;
    logic [1:0]  exp_err_code = 2'd0;
    logic [63:0] wq[$];

    uart_rx_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_byte    (rx_byte),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Observe accepted writes and frame pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data});
            if (frame_done) done_cnt++;
            if (frame_err)  err_cnt++;
        end
    end

    // Memory-side ready: 0 = always ready, 1 = never ready, 2 = random stalls of 0..3 cycles.
    initial begin
        int stall;
        stall    = 0;
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: wr_ready = 1'b1;
                1: wr_ready = 1'b0;
                default: begin
                    if (stall > 0) begin
                        wr_ready = 1'b0;
                        stall--;
                    end else begin
                        wr_ready = 1'b1;
                        stall    = $urandom_range(0, 3);
                    end
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic clear_obs();
        wq.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Sends one frame built from the format rules and checks every outcome.
    task automatic run_frame(input logic [31:0] a, input logic [7:0] d[$],
                             input bit bad, input int gap, input string tag);
        logic [7:0]  f[$];
        logic [7:0]  s;
        logic [63:0] obs;
        int          n;
        bit          ok;
        bit          exp_fail;
        n = d.size() / 4;
        f.push_back(8'hA5);
        for (int i = 0; i < 4; i++) f.push_back(a[8*i +: 8]);
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        foreach (d[i]) f.push_back(d[i]);
        s = 8'd0;
        for (int i = 1; i < f.size(); i++) s = s + f[i];
        if (CSUM_EN) f.push_back(bad ? s + 8'd1 : s);
        exp_fail = bad && CSUM_EN;
        if (exp_fail) exp_err_code = 2'd3;

        clear_obs();
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i]);
            if (i != f.size() - 1) idle(gap);
        end
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (done_cnt + err_cnt != 0) ok = 1'b1;
        end
        idle(4);
        chk({tag, "_end_seen"}, 64'(ok), 64'd1);
        chk({tag, "_wr_count"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            obs = (i < wq.size()) ? wq[i] : {64{1'bx}};
            chk({tag, "_write"}, obs,
                {a + 32'(4 * i), d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]});
        end
        chk({tag, "_done_pulses"}, 64'(done_cnt), exp_fail ? 64'd0 : 64'd1);
        chk({tag, "_err_pulses"},  64'(err_cnt),  exp_fail ? 64'd1 : 64'd0);
        chk({tag, "_err_code"},    64'(err_code), 64'(exp_err_code));
        chk({tag, "_busy"},        64'(busy),     64'd0);
    endtask

    initial begin
        logic [7:0] d[$];
        int         first;

        rst     = 1'b1;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid",   64'(wr_valid),   64'd0);
        chk("rst_wr_addr",    64'(wr_addr),    64'd0);
        chk("rst_wr_data",    64'(wr_data),    64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_frame_err",  64'(frame_err),  64'd0);
        chk("rst_err_code",   64'(err_code),   64'd0);
        rst = 1'b0;
        idle(2);

        // Clean reference frame with an always-ready memory.
        ready_mode = 0;
        d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_frame(32'h0000_1000, d, 1'b0, 1, "clean");
        chk("clean_w0_const", (wq.size() > 0) ? wq[0] : {64{1'bx}}, 64'h0000_1000_1234_5678);
        chk("clean_w1_const", (wq.size() > 1) ? wq[1] : {64{1'bx}}, 64'h0000_1004_DEAD_BEEF);

        run_frame(32'h0000_1000, d, 1'b1, 1, "bad_csum");

        d.delete();
        run_frame(32'h8000_0000, d, 1'b0, 1, "len0");

        // Overrun: memory never ready, second word completes with the first pending.
        ready_mode = 1;
        idle(2);
        clear_obs();
        d = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        foreach (d[i]) begin
            send_byte(d[i]);
            if (i == 10) chk("ovr_wr_valid_pending", 64'(wr_valid), 64'd1);
            if (i != d.size() - 1) idle(1);
        end
        exp_err_code = 2'd2;
        chk("ovr_frame_err", 64'(frame_err), 64'd1);
        chk("ovr_err_code",  64'(err_code),  64'd2);
        chk("ovr_wr_valid",  64'(wr_valid),  64'd0);
        chk("ovr_busy",      64'(busy),      64'd0);
        chk("ovr_no_writes", 64'(wq.size()), 64'd0);
        ready_mode = 0;
        idle(3);
        d = '{8'hC3, 8'h3C, 8'h5A, 8'h0F};
        run_frame(32'h0000_4000, d, 1'b0, 1, "after_ovr");

        // Timeout: garbage ignored, then a truncated header followed by silence.
        clear_obs();
        send_byte(8'h00);
        send_byte(8'hFF);
        idle(2);
        chk("garbage_busy", 64'(busy), 64'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        first = 0;
        for (int k = 1; k <= TO + 10; k++) begin
            @(posedge clk);
            #1;
            if (frame_err && first == 0) first = k;
        end
        exp_err_code = 2'd1;
        chk("to_latency",  64'(first),    64'(TO));
        chk("to_err_code", 64'(err_code), 64'd1);
        chk("to_busy",     64'(busy),     64'd0);

        // Asynchronous reset while a write is pending mid-payload.
        ready_mode = 1;
        idle(2);
        d = '{8'hA5, 8'h00, 8'h30, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h01, 8'h02, 8'h03, 8'h04};
        foreach (d[i]) begin
            send_byte(d[i]);
            idle(1);
        end
        chk("rstmid_wr_valid_pre", 64'(wr_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_err_code = 2'd0;
        chk("rstmid_wr_valid", 64'(wr_valid),   64'd0);
        chk("rstmid_busy",     64'(busy),       64'd0);
        chk("rstmid_wr_addr",  64'(wr_addr),    64'd0);
        chk("rstmid_wr_data",  64'(wr_data),    64'd0);
        chk("rstmid_err_code", 64'(err_code),   64'd0);
        chk("rstmid_flags",    64'({frame_done, frame_err}), 64'd0);
        #3;
        rst = 1'b0;
        ready_mode = 0;
        idle(2);
        d = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
        run_frame(32'h0000_5000, d, 1'b0, 1, "after_rst");

        // Random frames with random memory stalls; first wraps the address, second is all SYNC values.
        ready_mode = 2;
        for (int t = 0; t < 6; t++) begin
            logic [31:0] a;
            int          n;
            d.delete();
            a = (t == 0) ? 32'hFFFF_FFF8 : $urandom;
            n = (t == 0) ? 3 : $urandom_range(1, 4);
            for (int i = 0; i < 4 * n; i++) d.push_back((t == 1) ? 8'hA5 : 8'($urandom));
            run_frame(a, d, 1'b0, 2, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_loader.md
Name: uart_rx_loader

Overview:
- Byte-stream frame decoder directly downstream of the UART receiver. Consumes `rx_byte` qualified by `rx_done`.
- Parses a load frame (sync, address, word count, payload), assembles little-endian 32-bit words and issues them as memory writes with a valid/ready handshake.
- Used as the boot/program loader feeding instruction/data memory.
- Flags timeout, overrun and checksum errors, then resynchronises on the next sync byte.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame before abort; must be ≥ 1.
- CNT_W, 17, width of the inter-byte timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_done  in  1  one-cycle strobe: `rx_byte` is valid
- rx_byte  in  8  received byte
- wr_valid  out  1  write request pending
- wr_ready  in  1  memory accepts the write this cycle
- wr_addr  out  32  byte address of the current write
- wr_data  out  32  write data, little-endian assembled
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a frame completes cleanly
- frame_err  out  1  one-cycle pulse on abort
- err_code  out  2  cause of last abort (1 timeout, 2 overrun, 3 checksum); held until next abort or reset

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; `err_code`=0; internal counters and accumulators 0.
- Frame format: SYNC, ADDR[4] little-endian, LEN[2] little-endian word count, LEN×4 data bytes (LE per word), then CSUM[1] when the checksum feature is enabled.
- States and transitions:
  - IDLE: bytes ≠ SYNC_BYTE are ignored. SYNC → ADDR, byte index=0.
  - ADDR: 4 bytes, then → LEN.
  - LEN: 2 bytes. If LEN=0 → CSUM (feature on) or DONE (feature off). Otherwise → DATA.
  - DATA: on every 4th byte the word is complete: `wr_data`=word, `wr_addr`=current address, `wr_valid`=1 in the cycle after the 4th `rx_done`. After the last word → CSUM/DONE.
  - CSUM: one byte, compared, then → DONE or error.
  - DONE: `frame_done` pulses for one cycle → IDLE.
- Write handshake:
  - `wr_valid` stays high until the cycle `wr_ready`=1; it drops the next cycle. Address then advances by 4, wrapping mod 2^32.
  - `wr_ready` with `wr_valid` low is ignored.
  - Payload bytes keep accumulating while a write is pending.
- Frame completion with a write pending: DONE is entered only after the final write has been accepted. `frame_done` pulses in the cycle after the last handshake, or after the CSUM byte, whichever is later.
- Overrun: a new word completes while `wr_valid` is still high → abort, err 2. The pending write is dropped.
- Timeout:
  - Counter resets on every `rx_done` and while in IDLE.
  - When it reaches TIMEOUT_CYCLES in ADDR, LEN, DATA or CSUM → abort, err 1.
  - Waiting in DATA/CSUM for the final `wr_ready` does not count as a timeout.
- Abort: `frame_err` pulses for one cycle, `wr_valid`←0, state→IDLE. A SYNC byte in the abort cycle is ignored.
- A SYNC byte value seen mid-frame is treated as data, with no resync.
- `rx_done` arriving in the DONE cycle: the byte is dropped.

Optional Feature:
- Macro: UART_LOADER_CHECKSUM_EN.
- Defined: a CSUM byte follows the payload. It must equal the 8-bit sum of all bytes after SYNC (ADDR, LEN, data); a mismatch aborts with err 3. Data words are already written before the check; the mismatch is reported only.
- Undefined: no CSUM byte, no sum register; err 3 is never produced; the frame ends after the last data word.

Decomposition:
- Shared header/package (pinacolada_uart_pkg):
  - state encoding: IDLE, ADDR, LEN, DATA, CSUM, DONE
  - error code constants: ERR_TIMEOUT=1, ERR_OVERRUN=2, ERR_CSUM=3
  - default SYNC_BYTE
- One sub-module, uart_idle_timer: a clear/enable counter with a `expired` output, parameterised by TIMEOUT_CYCLES and CNT_W.

Test Plan:
- Clean frame A5 00 10 00 00 02 00 78 56 34 12 EF BE AD DE 5E (feature on), `wr_ready`=1 → writes (0x00001000, 0x12345678) then (0x00001004, 0xDEADBEEF); single `frame_done`; `err_code`=0.
- Same frame with CSUM=5F → both writes occur, then `frame_err` with `err_code`=3, `busy`=0.
- LEN=0: A5 00 00 00 80 00 00 80 → no writes; `frame_done` pulses after the CSUM byte.
- `wr_ready` held 0 through the first word, then the second word completes → `frame_err`, `err_code`=2, `wr_valid` drops, then a fresh frame decodes correctly.
- TIMEOUT_CYCLES=50: send A5 00 10, then silence → `frame_err` at 50 cycles after the last `rx_done`, `err_code`=1. Garbage bytes 00 FF before A5 are ignored.
- Assert `rst` mid-DATA with `wr_valid`=1 → all outputs are 0 immediately (asynchronously); the next full frame succeeds.
